// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: emits the index of each set bit of an
// accepted request word, one beat per handshake, in priority order.
module enc8to3_seq #(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out,
    output logic       out_last,
    output logic       out_none,
    output logic [3:0] out_count
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     state, state_n;
    logic [7:0] pending, pending_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] idx;
    logic       busy;
    logic       fire;
    logic       acc;

    function automatic logic [3:0] popcnt(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Later iterations overwrite earlier ones, so scan order picks the winner.
    always_comb begin
        idx = 3'd0;
        if (PRIO_MSB) begin
            for (int i = 0; i < 8; i++) begin
                if (pending[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending[i]) idx = 3'(i);
            end
        end
    end

    assign busy      = (state == BUSY);
    assign out_valid = busy;
    assign out       = busy ? idx : 3'd0;
    assign out_last  = busy & ((pending & (pending - 8'd1)) == 8'd0);
    assign out_none  = busy & (pending == 8'd0);
    assign out_count = cnt;
    assign fire      = out_valid & out_ready;
    assign in_ready  = ~busy | (fire & out_last);
    assign acc       = in_valid & in_ready;

    always_comb begin
        state_n   = state;
        pending_n = pending;
        cnt_n     = cnt;
        if (fire) begin
            pending_n = pending & ~(8'd1 << idx);
            if (out_last) begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        end
        // A new word on the final beat overrides the drain to IDLE.
        if (acc) begin
            pending_n = in;
            cnt_n     = popcnt(in);
            state_n   = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 8'd0;
            cnt     <= 4'd0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            cnt     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: both priority orders run in lockstep, each
// checked by its own scoreboard monitor.
module tb_enc8to3_seq;

    typedef struct packed {
        logic [2:0] o;
        logic       last;
        logic       none;
        logic [3:0] cnt;
        logic [7:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_d;
    logic       out_ready;

    logic       ir0, ov0, l0, n0;
    logic [2:0] o0;
    logic [3:0] c0;
    logic       ir1, ov1, l1, n1;
    logic [2:0] o1;
    logic [3:0] c1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   stamp[$];
    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    logic [7:0] acc0 = 8'd0;
    logic [7:0] acc1 = 8'd0;

    enc8to3_seq #(.PRIO_MSB(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir0), .in(in_d),
        .out_valid(ov0), .out_ready(out_ready), .out(o0),
        .out_last(l0), .out_none(n0), .out_count(c0)
    );

    enc8to3_seq #(.PRIO_MSB(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir1), .in(in_d),
        .out_valid(ov1), .out_ready(out_ready), .out(o1),
        .out_last(l1), .out_none(n1), .out_count(c1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic beat(input string tag, input exp_t e,
                        input logic [2:0] o, input logic l,
                        input logic n, input logic [3:0] c,
                        input logic [7:0] ai, output logic [7:0] ao);
        chk({tag, " out"}, 32'(o), 32'(e.o));
        chk({tag, " last"}, 32'(l), 32'(e.last));
        chk({tag, " none"}, 32'(n), 32'(e.none));
        chk({tag, " count"}, 32'(c), 32'(e.cnt));
        ao = ai;
        if (!n) ao = ai | (8'd1 << o);
        if (l) begin
            chk({tag, " decode"}, 32'(ao), 32'(e.word));
            ao = 8'd0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ov0 && out_ready) begin
            if (q0.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL msb beat: got out=%0d expected none", o0);
            end else begin
                e0 = q0.pop_front();
                stamp.push_back(cyc);
                beat("msb", e0, o0, l0, n0, c0, acc0, acc0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL lsb beat: got out=%0d expected none", o1);
            end else begin
                e1 = q1.pop_front();
                beat("lsb", e1, o1, l1, n1, c1, acc1, acc1);
            end
        end
    end

    // seq holds hand-written indices, first beat in the low 3 bits.
    task automatic push(input logic [7:0] w, input logic [23:0] s0,
                        input logic [23:0] s1, input int n);
        exp_t e;
        if (n == 0) begin
            e = '{o: 3'd0, last: 1'b1, none: 1'b1, cnt: 4'd0, word: w};
            q0.push_back(e);
            q1.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            e = '{o: s0[3*k +: 3], last: (k == n - 1), none: 1'b0,
                  cnt: 4'(n), word: w};
            q0.push_back(e);
            e.o = s1[3*k +: 3];
            q1.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [23:0] s0,
                        input logic [23:0] s1, input int n,
                        input bit hold);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_d     = w;
        while (!ir0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept in_ready", 32'(ir0), 32'd1);
        @(posedge clk);
        push(w, s0, s1, n);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ov0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain left", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_d      = 8'd0;
        out_ready = 1'b1;
        #1;
        chk("rst out_valid", 32'({ov0, ov1}), 32'd0);
        chk("rst out", 32'({o0, o1}), 32'd0);
        chk("rst last/none", 32'({l0, n0, l1, n1}), 32'd0);
        chk("rst count", 32'({c0, c1}), 32'd0);
        chk("rst in_ready", 32'({ir0, ir1}), 32'h3);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of an 8-beat word
        send(8'hFF, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
             {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'({ov0, ov1}), 32'd0);
        chk("midrst out", 32'({o0, o1}), 32'd0);
        chk("midrst count", 32'({c0, c1}), 32'd0);
        q0.delete();
        q1.delete();
        acc0 = 8'd0;
        acc1 = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst in_ready", 32'(ir0), 32'd1);

        send(8'h20, {21'd0, 3'd5}, {21'd0, 3'd5}, 1, 1'b0);
        @(negedge clk);
        chk("single valid", 32'(ov0), 32'd1);
        chk("single out", 32'(o0), 32'd5);
        chk("single last", 32'(l0), 32'd1);
        chk("single count", 32'(c0), 32'd1);
        @(negedge clk);
        chk("single idle", 32'(ov0), 32'd0);
        drain();

        send(8'hA5, {12'd0, 3'd0, 3'd2, 3'd5, 3'd7},
             {12'd0, 3'd7, 3'd5, 3'd2, 3'd0}, 4, 1'b0);
        drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h81, {18'd0, 3'd0, 3'd7}, {18'd0, 3'd7, 3'd0}, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall valid", 32'(ov0), 32'd1);
            chk("stall out msb", 32'(o0), 32'd7);
            chk("stall out lsb", 32'(o1), 32'd0);
            chk("stall in_ready", 32'(ir0), 32'd0);
            chk("stall count", 32'(c0), 32'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        send(8'h00, 24'd0, 24'd0, 0, 1'b0);
        @(negedge clk);
        chk("zero none", 32'({ov0, n0, l0}), 32'h7);
        drain();

        stamp.delete();
        send(8'h03, {18'd0, 3'd0, 3'd1}, {18'd0, 3'd1, 3'd0}, 2, 1'b1);
        send(8'h80, {21'd0, 3'd7}, {21'd0, 3'd7}, 1, 1'b0);
        drain();
        chk("b2b beats", 32'(stamp.size()), 32'd3);
        if (stamp.size() == 3)
            chk("b2b gap", 32'(stamp[2] - stamp[0]), 32'd2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
